// File: rtl/wb_req_bridge_if.sv
// Bus bundle for wb_req_bridge: the Wishbone-classic slave port toward the SoC
// and the held valid/ready request port toward the internal peripheral bus.
interface wb_req_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic [7:0]  err_count;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, ready, rdata,
    output wbs_ack_o, wbs_dat_o, valid, addr, wstrb, wdata, err_count
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, ready, rdata,
    input  wbs_ack_o, wbs_dat_o, valid, addr, wstrb, wdata, err_count
  );
endinterface

// File: rtl/wb_req_bridge.sv
// Registered Wishbone-classic slave that filters cycles through an address window and
// re-issues hits as a held valid/ready request, aborting stalled requests by timeout.
module wb_req_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT   = 32'd16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_req_bridge_if.slave bus
);
  localparam int unsigned   TW         = $clog2(TIMEOUT + 32'd1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 32'd1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic          r_valid, w_valid;
  logic [31:0]   r_addr, w_addr;
  logic [3:0]    r_wstrb, w_wstrb;
  logic [31:0]   r_wdata, w_wdata;
  logic [TW-1:0] r_timer, w_timer;
  logic          r_drop, w_drop;
  logic [7:0]    r_err, w_err;
  logic          r_ack, w_ack;
  logic [31:0]   r_dat_o, w_dat_o;

  logic w_hit;
  logic w_drop_now;
  logic w_timeout;
  logic w_fire;

  assign w_hit      = ((bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  // An abandon seen in the same cycle as completion still suppresses the ack.
  assign w_drop_now = r_drop | ~bus.wbs_cyc_i;
  assign w_timeout  = (r_timer == TIMER_LAST) & ~bus.ready;
  assign w_fire     = bus.ready | w_timeout;

  always_comb begin
    w_state = r_state;
    w_valid = r_valid;
    w_addr  = r_addr;
    w_wstrb = r_wstrb;
    w_wdata = r_wdata;
    w_timer = r_timer;
    w_drop  = r_drop;
    w_err   = r_err;
    w_ack   = 1'b0;
    w_dat_o = 32'h0000_0000;
    case (r_state)
      IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (w_hit) begin
            w_addr  = bus.wbs_adr_i & ~ADDR_MASK;
            w_wstrb = bus.wbs_sel_i & {4{bus.wbs_we_i}};
            w_wdata = bus.wbs_dat_i;
            w_valid = 1'b1;
            w_timer = {TW{1'b0}};
            w_drop  = 1'b0;
            w_state = REQ;
          end else begin
            w_ack   = 1'b1;
            w_state = RESP;
          end
        end else begin
          w_state = IDLE;
        end
      end
      REQ: begin
        w_drop = w_drop_now;
        if (w_fire) begin
          w_valid = 1'b0;
          if (w_timeout && (r_err != 8'hFF)) begin
            w_err = r_err + 8'd1;
          end else begin
            w_err = r_err;
          end
          if (w_drop_now) begin
            w_state = IDLE;
          end else begin
            w_state = RESP;
            w_ack   = 1'b1;
            w_dat_o = bus.ready ? bus.rdata : 32'hFFFF_FFFF;
          end
        end else begin
          w_timer = r_timer + TIMER_ONE;
        end
      end
      RESP: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wstrb <= 4'b0000;
      r_wdata <= 32'h0000_0000;
      r_timer <= {TW{1'b0}};
      r_drop  <= 1'b0;
      r_err   <= 8'h00;
      r_ack   <= 1'b0;
      r_dat_o <= 32'h0000_0000;
    end else begin
      r_state <= w_state;
      r_valid <= w_valid;
      r_addr  <= w_addr;
      r_wstrb <= w_wstrb;
      r_wdata <= w_wdata;
      r_timer <= w_timer;
      r_drop  <= w_drop;
      r_err   <= w_err;
      r_ack   <= w_ack;
      r_dat_o <= w_dat_o;
    end
  end

  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_dat_o;
  assign bus.valid     = r_valid;
  assign bus.addr      = r_addr;
  assign bus.wstrb     = r_wstrb;
  assign bus.wdata     = r_wdata;
  assign bus.err_count = r_err;
endmodule

// File: tb/tb_wb_req_bridge.sv
// Self-checking bench for wb_req_bridge: directed and randomized Wishbone cycles
// compared against a transaction-level model of window, latency and timeout rules.
module tb_wb_req_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0000;
  localparam int          TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  wb_req_bridge_if bus ();

  wb_req_bridge #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int exp_err  = 0;

  // Observations gathered by run_txn
  int          o_vcyc, o_acks, o_ack_at, o_unstable, o_leak;
  logic [31:0] o_ack_dat, o_addr, o_wdata;
  logic [3:0]  o_wstrb;

  typedef struct packed {
    int          vcyc;
    int          ack_at;
    logic        acked;
    logic [31:0] dat;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic        tmo;
  } exp_t;

  // Transaction-level model: lat = cycles after valid rises until ready (-1 = never),
  // abandon = cycle index (1 = cycle after acceptance) at which cyc drops, 0 = never.
  function automatic exp_t model(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                                 input int lat, input logic [31:0] rd, input int abandon);
    exp_t e;
    logic hit;
    hit     = ((adr & MASK) == BASE);
    e.addr  = adr & ~MASK;
    e.wstrb = we ? sel : 4'b0000;
    e.tmo   = 1'b0;
    if (!hit) begin
      e.vcyc = 0; e.acked = 1'b1; e.ack_at = 1; e.dat = 32'h0;
    end else begin
      if (lat >= 0 && lat < TMO) begin
        e.vcyc = lat + 1; e.dat = rd;
      end else begin
        e.vcyc = TMO; e.dat = 32'hFFFF_FFFF; e.tmo = 1'b1;
      end
      e.acked  = !(abandon >= 1 && abandon <= e.vcyc);
      e.ack_at = e.vcyc + 1;
    end
    return e;
  endfunction

  task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input int lat, input logic [31:0] rd,
                         input int abandon, input int window);
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    a0 = 32'h0; d0 = 32'h0; s0 = 4'h0;
    o_vcyc = 0; o_acks = 0; o_ack_at = -1; o_unstable = 0; o_leak = 0;
    o_ack_dat = 32'h0; o_addr = 32'h0; o_wdata = 32'h0; o_wstrb = 4'h0;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel; bus.wbs_we_i = we;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.ready = 1'b0;
    for (int n = 1; n <= window; n++) begin
      @(posedge clk); #1;
      bus.ready = 1'b0; bus.rdata = 32'hDEAD_BEEF;
      if (bus.valid) begin
        if (o_vcyc == 0) begin
          a0 = bus.addr; s0 = bus.wstrb; d0 = bus.wdata;
          o_addr = a0; o_wstrb = s0; o_wdata = d0;
        end else if (bus.addr !== a0 || bus.wstrb !== s0 || bus.wdata !== d0) begin
          o_unstable++;
        end
        o_vcyc++;
        if (o_vcyc == lat + 1) begin
          bus.ready = 1'b1; bus.rdata = rd;
        end
      end
      if (bus.wbs_ack_o) begin
        o_acks++;
        if (o_ack_at < 0) o_ack_at = n;
        o_ack_dat = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      end else if (bus.wbs_dat_o !== 32'h0) begin
        o_leak++;
      end
      if (n == abandon) begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", bus.valid); end
    n_checks++; if (bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %0b want 0", bus.wbs_ack_o); end
    n_checks++; if (bus.wbs_dat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %0h want 0", bus.wbs_dat_o); end
    n_checks++; if (bus.err_count !== 8'h0) begin n_err++; $display("FAIL reset_err: got %0d want 0", bus.err_count); end
    rst = 1'b0;
  endtask

  task automatic test_hit_write();
    exp_t e;
    e = model(32'h3000_0004, 4'b0011, 1'b1, 1, 32'h0, 0);
    run_txn(32'h3000_0004, 32'h1234_5678, 4'b0011, 1'b1, 1, 32'h0, 0, e.ack_at + 2);
    n_checks++; if (o_addr !== 32'h0000_0004) begin n_err++; $display("FAIL wr_addr: got %0h want 4", o_addr); end
    n_checks++; if (o_wstrb !== 4'b0011) begin n_err++; $display("FAIL wr_wstrb: got %0b want 0011", o_wstrb); end
    n_checks++; if (o_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL wr_wdata: got %0h want 12345678", o_wdata); end
    n_checks++; if (o_vcyc !== 2) begin n_err++; $display("FAIL wr_valid_cycles: got %0d want 2", o_vcyc); end
    n_checks++; if (o_acks !== 1 || o_ack_at !== 3) begin n_err++; $display("FAIL wr_ack: got %0d acks at %0d want 1 at 3", o_acks, o_ack_at); end
    n_checks++; if (o_unstable !== 0) begin n_err++; $display("FAIL wr_stable: got %0d changes want 0", o_unstable); end
  endtask

  task automatic test_hit_read();
    exp_t e;
    e = model(32'h3000_0010, 4'hF, 1'b0, 1, 32'hCAFE_0001, 0);
    run_txn(32'h3000_0010, 32'h5555_AAAA, 4'hF, 1'b0, 1, 32'hCAFE_0001, 0, e.ack_at + 2);
    n_checks++; if (o_ack_dat !== 32'hCAFE_0001) begin n_err++; $display("FAIL rd_data: got %0h want cafe0001", o_ack_dat); end
    n_checks++; if (o_leak !== 0) begin n_err++; $display("FAIL rd_dat_outside_ack: got %0d cycles want 0", o_leak); end
    n_checks++; if (o_wstrb !== 4'b0000) begin n_err++; $display("FAIL rd_wstrb: got %0b want 0000", o_wstrb); end
    n_checks++; if (o_acks !== 1 || o_ack_at !== e.ack_at) begin n_err++; $display("FAIL rd_ack: got %0d acks at %0d want 1 at %0d", o_acks, o_ack_at, e.ack_at); end
  endtask

  task automatic test_miss();
    run_txn(32'h2000_0000, 32'hFFFF_0000, 4'hF, 1'b1, 0, 32'h0, 0, 3);
    n_checks++; if (o_vcyc !== 0) begin n_err++; $display("FAIL miss_valid: got %0d cycles want 0", o_vcyc); end
    n_checks++; if (o_acks !== 1 || o_ack_at !== 1) begin n_err++; $display("FAIL miss_ack: got %0d acks at %0d want 1 at 1", o_acks, o_ack_at); end
    n_checks++; if (o_ack_dat !== 32'h0) begin n_err++; $display("FAIL miss_data: got %0h want 0", o_ack_dat); end
    n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_err++; $display("FAIL miss_err: got %0d want %0d", bus.err_count, exp_err); end
  endtask

  task automatic test_timeout();
    exp_t e;
    e = model(32'h3000_0100, 4'hF, 1'b0, -1, 32'h0, 0);
    run_txn(32'h3000_0100, 32'h0, 4'hF, 1'b0, -1, 32'h0, 0, e.ack_at + 2);
    if (e.tmo) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    n_checks++; if (o_vcyc !== 16) begin n_err++; $display("FAIL tmo_valid_cycles: got %0d want 16", o_vcyc); end
    n_checks++; if (o_acks !== 1 || o_ack_at !== 17) begin n_err++; $display("FAIL tmo_ack: got %0d acks at %0d want 1 at 17", o_acks, o_ack_at); end
    n_checks++; if (o_ack_dat !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL tmo_data: got %0h want ffffffff", o_ack_dat); end
    n_checks++; if (bus.err_count !== 8'd1) begin n_err++; $display("FAIL tmo_err: got %0d want 1", bus.err_count); end
    // ready in the final cycle wins over the timeout
    e = model(32'h3000_0104, 4'hF, 1'b0, TMO - 1, 32'h0BAD_F00D, 0);
    run_txn(32'h3000_0104, 32'h0, 4'hF, 1'b0, TMO - 1, 32'h0BAD_F00D, 0, e.ack_at + 2);
    n_checks++; if (o_vcyc !== e.vcyc || o_ack_at !== e.ack_at) begin n_err++; $display("FAIL tmo_edge_timing: got %0d/%0d want %0d/%0d", o_vcyc, o_ack_at, e.vcyc, e.ack_at); end
    n_checks++; if (o_ack_dat !== 32'h0BAD_F00D) begin n_err++; $display("FAIL tmo_edge_data: got %0h want 0badf00d", o_ack_dat); end
    n_checks++; if (bus.err_count !== 8'd1) begin n_err++; $display("FAIL tmo_edge_err: got %0d want 1", bus.err_count); end
  endtask

  task automatic test_reset_mid_req();
    exp_t e;
    bus.wbs_adr_i = 32'h3000_0200; bus.wbs_dat_i = 32'h7777_7777; bus.wbs_sel_i = 4'hF; bus.wbs_we_i = 1'b1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL rstreq_pre_valid: got %0b want 1", bus.valid); end
    rst = 1'b1; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.valid !== 1'b0 || bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin n_err++; $display("FAIL rstreq_handshake: got v=%0b a=%0b d=%0h want 0", bus.valid, bus.wbs_ack_o, bus.wbs_dat_o); end
    n_checks++; if (bus.addr !== 32'h0 || bus.wstrb !== 4'h0 || bus.wdata !== 32'h0) begin n_err++; $display("FAIL rstreq_latched: got %0h/%0h/%0h want 0", bus.addr, bus.wstrb, bus.wdata); end
    n_checks++; if (bus.err_count !== 8'h0) begin n_err++; $display("FAIL rstreq_err: got %0d want 0", bus.err_count); end
    rst = 1'b0; exp_err = 0;
    e = model(32'h3000_0208, 4'hF, 1'b0, 2, 32'h1111_2222, 0);
    run_txn(32'h3000_0208, 32'h0, 4'hF, 1'b0, 2, 32'h1111_2222, 0, e.ack_at + 2);
    n_checks++; if (o_acks !== 1 || o_ack_at !== 4 || o_ack_dat !== 32'h1111_2222) begin n_err++; $display("FAIL rstreq_after: got %0d acks at %0d data %0h want 1 at 4 data 11112222", o_acks, o_ack_at, o_ack_dat); end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [31:0] adr, dat, rd, lo;
    logic [3:0]  sel;
    logic        we;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      lo  = $urandom();
      adr = ($urandom_range(0, 9) < 7) ? (BASE | (lo & ~MASK)) : $urandom();
      dat = $urandom(); rd = $urandom();
      sel = 4'($urandom_range(0, 15)); we = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, TMO + 2);
      e = model(adr, sel, we, lat, rd, 0);
      run_txn(adr, dat, sel, we, lat, rd, 0, e.ack_at + 2);
      if (e.tmo) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      n_checks++; if (o_vcyc !== e.vcyc || o_acks !== 1 || o_ack_at !== e.ack_at) begin n_err++; $display("FAIL rand_timing[%0d]: got v=%0d acks=%0d at=%0d want v=%0d acks=1 at=%0d", i, o_vcyc, o_acks, o_ack_at, e.vcyc, e.ack_at); end
      n_checks++; if (o_ack_dat !== e.dat || o_leak !== 0) begin n_err++; $display("FAIL rand_data[%0d]: got %0h leak=%0d want %0h leak=0", i, o_ack_dat, o_leak, e.dat); end
      if (e.vcyc > 0) begin
        n_checks++; if (o_addr !== e.addr || o_wstrb !== e.wstrb || o_wdata !== dat || o_unstable !== 0) begin n_err++; $display("FAIL rand_req[%0d]: got %0h/%0h/%0h unstable=%0d want %0h/%0h/%0h", i, o_addr, o_wstrb, o_wdata, o_unstable, e.addr, e.wstrb, dat); end
      end
      n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_err++; $display("FAIL rand_err[%0d]: got %0d want %0d", i, bus.err_count, exp_err); end
    end
  endtask

  task automatic test_abandon();
    exp_t e;
    e = model(32'h3000_0300, 4'hF, 1'b0, 3, 32'h3333_3333, 2);
    run_txn(32'h3000_0300, 32'h0, 4'hF, 1'b0, 3, 32'h3333_3333, 2, e.ack_at + 3);
    n_checks++; if (o_acks !== 0 || o_vcyc !== e.vcyc) begin n_err++; $display("FAIL abandon_ready: got %0d acks v=%0d want 0 acks v=%0d", o_acks, o_vcyc, e.vcyc); end
    e = model(32'h3000_0304, 4'hF, 1'b0, -1, 32'h0, 1);
    run_txn(32'h3000_0304, 32'h0, 4'hF, 1'b0, -1, 32'h0, 1, e.ack_at + 3);
    if (e.tmo) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    n_checks++; if (o_acks !== 0 || o_vcyc !== TMO) begin n_err++; $display("FAIL abandon_tmo: got %0d acks v=%0d want 0 acks v=%0d", o_acks, o_vcyc, TMO); end
    n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_err++; $display("FAIL abandon_err: got %0d want %0d", bus.err_count, exp_err); end
    e = model(32'h3000_0308, 4'hF, 1'b0, 0, 32'h4444_4444, 0);
    run_txn(32'h3000_0308, 32'h0, 4'hF, 1'b0, 0, 32'h4444_4444, 0, e.ack_at + 2);
    n_checks++; if (o_acks !== 1 || o_ack_at !== 2 || o_ack_dat !== 32'h4444_4444) begin n_err++; $display("FAIL abandon_idle: got %0d acks at %0d data %0h want 1 at 2 data 44444444", o_acks, o_ack_at, o_ack_dat); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          vrun, acks, at0, at1, dbl;
    logic [31:0] d0, d1;
    logic        prev_ack;
    vrun = 0; acks = 0; at0 = -1; at1 = -1; dbl = 0; d0 = 32'h0; d1 = 32'h0; prev_ack = 1'b0;
    e = model(32'h3000_0020, 4'hF, 1'b0, 1, 32'h0, 0);
    bus.wbs_adr_i = 32'h3000_0020; bus.wbs_sel_i = 4'hF; bus.wbs_we_i = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      bus.ready = 1'b0; bus.rdata = 32'hDEAD_BEEF;
      if (bus.valid) begin
        vrun++;
        if (vrun == 2) begin
          bus.ready = 1'b1; bus.rdata = (acks == 0) ? 32'h0B2B_0001 : 32'h0B2B_0002;
        end
      end else begin
        vrun = 0;
      end
      if (bus.wbs_ack_o) begin
        if (prev_ack) dbl++;
        if (acks == 0) begin at0 = n; d0 = bus.wbs_dat_o; end
        else if (acks == 1) begin at1 = n; d1 = bus.wbs_dat_o; end
        acks++;
        if (acks == 2) begin bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; end
      end
      prev_ack = bus.wbs_ack_o;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    n_checks++; if (acks !== 2 || dbl !== 0) begin n_err++; $display("FAIL b2b_count: got %0d acks %0d adjacent want 2 acks 0 adjacent", acks, dbl); end
    n_checks++; if (at0 !== e.ack_at || at1 !== 2 * e.ack_at + 1) begin n_err++; $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d", at0, at1, e.ack_at, 2 * e.ack_at + 1); end
    n_checks++; if (d0 !== 32'h0B2B_0001 || d1 !== 32'h0B2B_0002) begin n_err++; $display("FAIL b2b_data: got %0h,%0h want b2b0001,b2b0002", d0, d1); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      run_txn(32'h3000_0400, 32'h0, 4'hF, 1'b0, -1, 32'h0, 0, TMO + 3);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end
    n_checks++; if (bus.err_count !== 8'd255) begin n_err++; $display("FAIL sat_err: got %0d want 255", bus.err_count); end
    n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_err++; $display("FAIL sat_model: got %0d want %0d", bus.err_count, exp_err); end
  endtask

  initial begin
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0; bus.ready = 1'b0; bus.rdata = 32'h0;
    test_reset();
    test_hit_write();
    test_hit_read();
    test_miss();
    test_timeout();
    test_reset_mid_req();
    test_random();
    test_abandon();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
